// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types, feed/capture timing constants and lane helpers for the sequencer.
package systolic_pkg;
  localparam int N          = 4;
  localparam int LANE_W     = 8;
  localparam int Y_LAT      = N + 1;
  localparam int T_W        = $clog2(3 * N + Y_LAT + 2 * N);
  localparam int R_W        = $clog2(N) + 1;
  localparam int W_END      = N;
  localparam int A_END      = 3 * N;
  localparam int CAP_T0     = N + Y_LAT;
  localparam int CAP_T_LAST = CAP_T0 + 2 * (N - 1);
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_A, WAIT_RDY, START, FEED, WAIT_DONE, OUT} state_e;
  typedef logic [LANE_W-1:0] lane_t;
  typedef lane_t [N-1:0] row_t;
  // Out-of-range indices (including wrapped negatives) select a zero lane.
  function automatic lane_t lane_sel(row_t row, logic [T_W-1:0] idx);
    return (idx < T_W'(N)) ? row[idx[$clog2(N)-1:0]] : '0;
  endfunction
endpackage

// File: rtl/systolic_deskew.sv
// systolic_deskew: captures skewed y_out lanes into an NxN result buffer at t = CAP_T0 + r + c.
module systolic_deskew
  import systolic_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [T_W-1:0]        t,
  input  logic [N*LANE_W-1:0]   y_in,
  input  logic [$clog2(N)-1:0]  rd_row,
  output logic [N*LANE_W-1:0]   rd_data,
  output logic                  all_captured
);
  row_t [N-1:0] y_q, y_d;
  logic all_q, all_d;
  always_comb begin
    y_d = y_q;
    all_d = clr ? 1'b0 : all_q;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (en && t == T_W'(CAP_T0 + r + c)) y_d[r][c] = y_in[c*LANE_W +: LANE_W];
    if (en && t == T_W'(CAP_T_LAST)) all_d = 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q   <= '0;
      all_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      all_q <= all_d;
    end
  end
  assign rd_data      = y_q[rd_row];
  assign all_captured = all_q;
endmodule

// File: rtl/systolic_sequencer.sv
// systolic_sequencer: job controller that loads W/A, preloads weights, feeds skewed
// activations into the array, de-skews results and streams result rows to the host.
module systolic_sequencer
  import systolic_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                job_go,
  output logic                busy,
  output logic                err,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*LANE_W-1:0] in_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [N*LANE_W-1:0] res_data,
  output logic                arr_start,
  input  logic                arr_ready,
  input  logic                arr_done,
  output logic [N*LANE_W-1:0] arr_a_in,
  output logic [N*LANE_W-1:0] arr_w_in,
  input  logic [N*LANE_W-1:0] arr_y_out
);
  localparam int RI = $clog2(N);
  state_e state_q, state_d;
  logic [R_W-1:0] row_q, row_d;
  logic [T_W-1:0] t_q, t_d, s;
  row_t [N-1:0] w_q, w_d, a_q, a_d;
  logic err_q, err_d, done_q, done_d, all_captured;
  logic [N*LANE_W-1:0] rd_data;

  systolic_deskew u_deskew (
    .clk          (clk),
    .rst          (rst),
    .clr          (state_q == START),
    .en           (state_q == FEED),
    .t            (t_q),
    .y_in         (arr_y_out),
    .rd_row       (row_q[RI-1:0]),
    .rd_data      (rd_data),
    .all_captured (all_captured)
  );

  always_comb begin
    state_d = state_q;
    row_d = row_q;
    t_d = t_q;
    w_d = w_q;
    a_d = a_q;
    err_d = err_q;
    done_d = done_q;
    s = t_q - T_W'(N);
    in_ready = 1'b0;
    arr_start = 1'b0;
    arr_a_in = '0;
    arr_w_in = '0;
    res_valid = 1'b0;
    res_data = '0;
    case (state_q)
      IDLE: if (job_go) begin
        state_d = LOAD_W;
        err_d = 1'b0;
        done_d = 1'b0;
        row_d = '0;
      end
      LOAD_W, LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (state_q == LOAD_W) w_d[row_q[RI-1:0]] = in_data;
          else a_d[row_q[RI-1:0]] = in_data;
          row_d = row_q + R_W'(1);
          if (row_q == R_W'(N - 1)) begin
            row_d = '0;
            state_d = (state_q == LOAD_W) ? LOAD_A : WAIT_RDY;
          end
        end
      end
      WAIT_RDY: if (arr_ready) state_d = START;
      START: begin
        arr_start = 1'b1;
        t_d = '0;
        done_d = 1'b0;
        state_d = FEED;
      end
      FEED: begin
        t_d = t_q + T_W'(1);
        // Weights enter column N-1 first; activation row r is delayed r beats.
        for (int r = 0; r < N; r++) begin
          if (t_q < T_W'(W_END)) arr_w_in[r*LANE_W +: LANE_W] = lane_sel(w_q[r], T_W'(N - 1) - t_q);
          else if (t_q < T_W'(A_END)) arr_a_in[r*LANE_W +: LANE_W] = lane_sel(a_q[r], s - T_W'(r));
        end
        if (arr_done) begin
          done_d = 1'b1;
          if (!all_captured) err_d = 1'b1;
        end
        if (all_captured) state_d = WAIT_DONE;
      end
      WAIT_DONE: if (arr_done || done_q) begin
        state_d = OUT;
        row_d = '0;
      end
      OUT: begin
        res_valid = 1'b1;
        res_data = rd_data;
        if (res_ready) begin
          row_d = row_q + R_W'(1);
          if (row_q == R_W'(N - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      t_q     <= '0;
      w_q     <= '0;
      a_q     <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      t_q     <= t_d;
      w_q     <= w_d;
      a_q     <= a_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy = state_q != IDLE;
  assign err  = err_q;
endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer: scoreboard bench with a timing model of the systolic array.
module tb_systolic_sequencer;
  localparam int N = 4;
  localparam int Y_LAT = N + 1;
  logic clk = 1'b0, rst = 1'b0, job_go = 1'b0, in_valid = 1'b0, res_ready = 1'b1;
  logic arr_ready = 1'b1, arr_done = 1'b0;
  logic busy, err, in_ready, res_valid, arr_start;
  logic [31:0] in_data = '0, res_data, arr_a_in, arr_w_in, arr_y_out = '0;
  int n_cmp = 0, n_bad = 0, ft = -1, done_s = 14, start_cnt = 0;
  bit pend = 0, feed_chk = 0, prev_stall = 0;
  logic [31:0] prev_data;
  logic [31:0] q_exp[$];
  int exp_b[4][4] = '{'{7, 14, 21, 28}, '{9, 18, 27, 36}, '{8, 16, 24, 32}, '{10, 20, 30, 40}};
  logic [31:0] w_rows[4] = '{32'h04030201, 32'h04030201, 32'h04030201, 32'h04030201};
  logic [31:0] a_rows[4] = '{32'h01020004, 32'h00020304, 32'h01000304, 32'h01020304};

  always #5 clk = ~clk;

  systolic_sequencer dut (
    .clk(clk), .rst(rst), .job_go(job_go), .busy(busy), .err(err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .arr_start(arr_start), .arr_ready(arr_ready), .arr_done(arr_done),
    .arr_a_in(arr_a_in), .arr_w_in(arr_w_in), .arr_y_out(arr_y_out)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  function automatic logic [31:0] exp_row(input int r);
    logic [31:0] v;
    for (int c = 0; c < N; c++) v[c*8 +: 8] = 8'(exp_b[r][c]);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Array timing model: y_out lane c carries Y[r][c] at s = Y_LAT + r + c, junk otherwise.
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst) begin
      ft = -1;
      pend = 0;
    end else if (pend) begin
      ft = 0;
      pend = 0;
    end else if (ft >= 0) ft = (ft >= 40) ? -1 : ft + 1;
    if (rst && arr_start) pend = 1;
    arr_done = (ft >= 0) && (ft == N + done_s);
    for (int c = 0; c < N; c++) begin
      int r;
      r = ft - N - Y_LAT - c;
      arr_y_out[c*8 +: 8] = (ft >= 0 && r >= 0 && r < N) ? 8'(exp_b[r][c]) : 8'hEE;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (arr_start) start_cnt++;
      if (res_valid && prev_stall) check("res_hold", res_data, prev_data);
      prev_stall = res_valid && !res_ready;
      prev_data = res_data;
      if (res_valid && res_ready) begin
        if (q_exp.size() == 0) timeout("res_row_unexpected");
        else check("res_row", res_data, q_exp.pop_front());
      end
      if (feed_chk) begin
        if (ft == 0) begin
          check("feed_w_t0", arr_w_in, 32'h04040404);
          check("feed_a_t0", arr_a_in, 32'h0);
        end
        if (ft == 1) check("feed_w_t1", arr_w_in, 32'h03030303);
        if (ft == N) begin
          check("feed_a_s0", arr_a_in, 32'h00000004);
          check("feed_w_s0", arr_w_in, 32'h0);
        end
        if (ft == N + 3) check("feed_a_s3", arr_a_in, 32'h04030201);
        if (ft == N + 6) check("feed_a_s6", arr_a_in, 32'h01000000);
        if (ft == 3 * N) check("feed_a_end", arr_a_in | arr_w_in, 32'h0);
      end
    end
  end

  task automatic go();
    job_go = 1'b1;
    step();
    job_go = 1'b0;
  endtask

  task automatic send_row(input logic [31:0] d);
    int g = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && g < 100) begin
      step();
      g++;
    end
    if (!in_ready) timeout("in_ready");
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_all(input bit push);
    if (push) for (int r = 0; r < N; r++) q_exp.push_back(exp_row(r));
    for (int r = 0; r < N; r++) send_row(w_rows[r]);
    for (int r = 0; r < N; r++) send_row(a_rows[r]);
  endtask

  task automatic wait_ft(input int k);
    int g = 0;
    while (ft != k && g < 200) begin
      step();
      g++;
    end
    if (ft != k) timeout("wait_feed");
  endtask

  task automatic finish_job(input logic exp_err);
    int g = 0;
    while (busy && g < 400) begin
      step();
      g++;
    end
    if (busy) timeout("job_end");
    check("err", err, exp_err);
    check("rows_left", q_exp.size(), 0);
  endtask

  initial begin
    int g;
    int s0;
    logic bad;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_arr_start", arr_start, 0);
    check("rst_a_in", arr_a_in, 0);
    check("rst_w_in", arr_w_in, 0);
    check("rst_res_data", res_data, 0);
    rst = 1'b1;
    step();
    feed_chk = 1;
    go();
    check("busy_go", busy, 1);
    send_all(1);
    finish_job(0);
    feed_chk = 0;
    go();
    send_all(1);
    g = 0;
    while (!res_valid && g < 200) begin
      step();
      g++;
    end
    if (!res_valid) timeout("res_valid");
    step();
    step();
    res_ready = 1'b0;
    repeat (5) step();
    res_ready = 1'b1;
    finish_job(0);
    arr_ready = 1'b0;
    s0 = start_cnt;
    go();
    send_all(1);
    bad = 0;
    repeat (10) begin
      step();
      if (arr_start) bad = 1;
    end
    check("start_while_not_ready", bad, 0);
    check("busy_wait_rdy", busy, 1);
    arr_ready = 1'b1;
    finish_job(0);
    check("start_pulses", start_cnt - s0, 1);
    go();
    send_all(1);
    wait_ft(2);
    job_go = 1'b1;
    in_valid = 1'b1;
    in_data = '1;
    bad = 0;
    repeat (12) begin
      step();
      job_go = 1'b0;
      if (in_ready) bad = 1;
    end
    in_valid = 1'b0;
    check("in_ready_feed", bad, 0);
    finish_job(0);
    step();
    check("idle_after_ignored_go", busy, 0);
    go();
    send_all(1);
    wait_ft(3);
    rst = 1'b0;
    #1;
    check("abort_w_in", arr_w_in, 0);
    check("abort_a_in", arr_a_in, 0);
    check("abort_busy", busy, 0);
    check("abort_start", arr_start, 0);
    check("abort_res_valid", res_valid, 0);
    check("abort_in_ready", in_ready, 0);
    q_exp.delete();
    step();
    step();
    rst = 1'b1;
    step();
    go();
    send_all(1);
    finish_job(0);
    done_s = 0;
    go();
    send_all(1);
    finish_job(1);
    done_s = 14;
    go();
    check("err_clear", err, 0);
    send_all(1);
    finish_job(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
